// File: rtl/cluster_evt_pkg.sv
// Shared definitions for the SoC->cluster event bus: Johnson token helpers,
// ring constants and the event payload type.
package cluster_evt_pkg;

  // Default build widths of the event bus.
  localparam int unsigned BUFFER_WIDTH_DEF = 8;
  localparam int unsigned EVNT_WIDTH_DEF   = 8;

  // A W-slot buffer is addressed by a Johnson ring of 2W states.
  localparam int unsigned EVT_RING_STATES  = 2 * BUFFER_WIDTH_DEF;

  // Widest token the helper functions accept; callers size-cast in and out.
  localparam int unsigned JW_MAX = 32;

  typedef logic [EVNT_WIDTH_DEF-1:0] evt_payload_t;

  // Advance a w-bit Johnson code: shift left, feed back the inverted MSB.
  function automatic logic [JW_MAX-1:0] johnson_next(input logic [JW_MAX-1:0] c,
                                                      input int unsigned     w);
    logic [JW_MAX-1:0] n;
    n = '0;
    for (int unsigned i = 1; i < JW_MAX; i++) begin
      if (i < w) n[i] = c[i-1];
    end
    n[0] = ~c[w-1];
    return n;
  endfunction

  // Decode a w-bit Johnson code to its ring position 0..2w-1. The filling half
  // (LSB set, or all-zero) counts ones; the draining half counts back from 2w.
  function automatic int unsigned johnson_to_idx(input logic [JW_MAX-1:0] c,
                                                 input int unsigned     w);
    int unsigned pc;
    pc = 0;
    for (int unsigned i = 0; i < JW_MAX; i++) begin
      if (i < w && c[i]) pc++;
    end
    if (c == '0 || c[0]) return pc;
    else                 return 2 * w - pc;
  endfunction

endpackage

// File: rtl/cluster_evt_token_sync.sv
// Per-bit multi-flop synchroniser bank for Johnson-coded tokens. Safe because
// a Johnson token changes exactly one bit per step.
module cluster_evt_token_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the asynchronous token through STAGES flops; clear on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < STAGES; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/cluster_evt_rx.sv
// Cluster-side receiver of the SoC->cluster event bus. Synchronises the
// sender's write token, pops slots in order into a one-entry output register
// on a valid/ready stream, and returns the Johnson read pointer.
module cluster_evt_rx
  import cluster_evt_pkg::*;
#(
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned EVNT_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [BUFFER_WIDTH-1:0]            evt_writetoken_i,
  input  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] evt_data_i,
  output logic [BUFFER_WIDTH-1:0]            evt_readpointer_o,
  output logic                               evt_valid_o,
  output logic [EVNT_WIDTH-1:0]              evt_data_o,
  input  logic                               evt_ready_i,
  output logic [$clog2(BUFFER_WIDTH+1)-1:0]  evt_level_o,
  output logic                               evt_err_o
);

  localparam int unsigned W    = BUFFER_WIDTH;
  localparam int unsigned RING = 2 * W;
  localparam int unsigned LW   = $clog2(BUFFER_WIDTH + 1);

  logic [W-1:0]          w_wt_s;
  logic [W-1:0]          w_rp_next;
  logic [EVNT_WIDTH-1:0] w_slot_data;
  logic                  w_ring_empty;
  logic                  w_load;
  logic                  w_overrun;
  int unsigned           w_wt_idx;
  int unsigned           w_rp_idx;
  int unsigned           w_dist;
  int unsigned           w_slot;

  logic [W-1:0]          r_rp;
  logic                  r_out_valid;
  logic [EVNT_WIDTH-1:0] r_out_data;
  logic                  r_err;

  cluster_evt_token_sync #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_wt_sync (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (evt_writetoken_i),
    .o_q   (w_wt_s)
  );

  // Ring occupancy, read slot selection and pop decision.
  always_comb begin
    w_wt_idx = johnson_to_idx(JW_MAX'(w_wt_s), W);
    w_rp_idx = johnson_to_idx(JW_MAX'(r_rp), W);
    // Modular distance without a divider: both indices are below RING.
    w_dist   = w_wt_idx + RING - w_rp_idx;
    if (w_dist >= RING) w_dist = w_dist - RING;
    w_slot   = (w_rp_idx >= W) ? (w_rp_idx - W) : w_rp_idx;
    w_ring_empty = (w_wt_s == r_rp);
    w_load       = !w_ring_empty && (!r_out_valid || evt_ready_i);
    w_overrun    = (w_dist > W);
    w_slot_data  = evt_data_i[w_slot*EVNT_WIDTH +: EVNT_WIDTH];
    w_rp_next    = W'(johnson_next(JW_MAX'(r_rp), W));
  end

  // Output register and read pointer; a load while the consumer takes the
  // current entry replaces it in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rp        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_data  <= w_slot_data;
      r_out_valid <= 1'b1;
      r_rp        <= w_rp_next;
    end else if (r_out_valid && evt_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overrun flag: set once the sender runs more than W ahead.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_err <= 1'b0;
    else if (w_overrun) r_err <= 1'b1;
  end

  assign evt_readpointer_o = r_rp;
  assign evt_valid_o       = r_out_valid;
  assign evt_data_o        = r_out_data;
  assign evt_err_o         = r_err;
  assign evt_level_o       = w_overrun ? LW'(W) : LW'(w_dist);

endmodule

// File: tb/tb_cluster_evt_rx.sv
// Directed testbench for cluster_evt_rx (W=8, EVNT_WIDTH=8, SYNC_STAGES=2).
module tb_cluster_evt_rx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  evt_writetoken_i;
  logic [63:0] evt_data_i;
  logic [7:0]  evt_readpointer_o;
  logic        evt_valid_o;
  logic [7:0]  evt_data_o;
  logic        evt_ready_i;
  logic [3:0]  evt_level_o;
  logic        evt_err_o;

  int npass = 0;
  int nchk  = 0;

  cluster_evt_rx #(
    .BUFFER_WIDTH (8),
    .EVNT_WIDTH   (8),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .evt_writetoken_i  (evt_writetoken_i),
    .evt_data_i        (evt_data_i),
    .evt_readpointer_o (evt_readpointer_o),
    .evt_valid_o       (evt_valid_o),
    .evt_data_o        (evt_data_o),
    .evt_ready_i       (evt_ready_i),
    .evt_level_o       (evt_level_o),
    .evt_err_o         (evt_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] jnext(input logic [7:0] c);
    return {c[6:0], ~c[7]};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    evt_writetoken_i = 8'h00;
    evt_data_i = '0;
    evt_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    nchk++; if (evt_readpointer_o !== 8'h00) $display("FAIL reset_rp: got %h want 00", evt_readpointer_o); else npass++;
    nchk++; if (evt_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", evt_valid_o); else npass++;
    nchk++; if (evt_data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", evt_data_o); else npass++;
    nchk++; if (evt_level_o !== 4'd0) $display("FAIL reset_level: got %0d want 0", evt_level_o); else npass++;
    nchk++; if (evt_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", evt_err_o); else npass++;
  endtask

  // One event through an idle receiver: valid appears 3 edges after the token.
  task automatic test_single();
    evt_ready_i = 1'b1;
    evt_data_i[7:0] = 8'hA5;
    @(posedge clk_i); #1;           // edge n
    evt_writetoken_i = 8'h01;
    tick();                          // n+1
    tick();                          // n+2
    nchk++; if (evt_valid_o !== 1'b0) $display("FAIL single_early_valid: got %b want 0", evt_valid_o); else npass++;
    tick();                          // n+3
    nchk++; if (evt_valid_o !== 1'b1) $display("FAIL single_valid: got %b want 1", evt_valid_o); else npass++;
    nchk++; if (evt_data_o !== 8'hA5) $display("FAIL single_data: got %h want a5", evt_data_o); else npass++;
    nchk++; if (evt_readpointer_o !== 8'h01) $display("FAIL single_rp: got %h want 01", evt_readpointer_o); else npass++;
    tick();                          // n+4
    nchk++; if (evt_valid_o !== 1'b0) $display("FAIL single_drop: got %b want 0", evt_valid_o); else npass++;
    evt_ready_i = 1'b0;
  endtask

  // Full ring with back-pressure, then drain at one event per cycle.
  task automatic test_full_ring();
    logic [7:0] tok;
    do_reset();
    for (int k = 0; k < 8; k++) evt_data_i[k*8 +: 8] = 8'h10 + 8'(k);
    tok = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tok = jnext(tok);
      evt_writetoken_i = tok;
      tick();
    end
    for (int k = 0; k < 4; k++) tick();
    nchk++; if (evt_valid_o !== 1'b1) $display("FAIL full_valid: got %b want 1", evt_valid_o); else npass++;
    nchk++; if (evt_data_o !== 8'h10) $display("FAIL full_data: got %h want 10", evt_data_o); else npass++;
    nchk++; if (evt_level_o !== 4'd7) $display("FAIL full_level: got %0d want 7", evt_level_o); else npass++;
    nchk++; if (evt_readpointer_o !== 8'h01) $display("FAIL full_rp: got %h want 01", evt_readpointer_o); else npass++;
    tick();
    tick();
    nchk++; if (evt_data_o !== 8'h10) $display("FAIL full_hold: got %h want 10", evt_data_o); else npass++;
    evt_ready_i = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      nchk++; if (evt_valid_o !== 1'b1 || evt_data_o !== 8'h10 + 8'(k))
        $display("FAIL drain_%0d: got valid=%b data=%h want valid=1 data=%h", k, evt_valid_o, evt_data_o, 8'h10 + 8'(k));
      else npass++;
    end
    nchk++; if (evt_readpointer_o !== 8'hFF) $display("FAIL drain_rp: got %h want ff", evt_readpointer_o); else npass++;
    nchk++; if (evt_level_o !== 4'd0) $display("FAIL drain_level: got %0d want 0", evt_level_o); else npass++;
    tick();
    nchk++; if (evt_valid_o !== 1'b0) $display("FAIL drain_end_valid: got %b want 0", evt_valid_o); else npass++;
    nchk++; if (evt_err_o !== 1'b0) $display("FAIL drain_err: got %b want 0", evt_err_o); else npass++;
    evt_ready_i = 1'b0;
  endtask

  // 20 events with random ready, crossing the ring wrap.
  task automatic test_stream();
    logic [7:0] tok;
    int sent;
    int recv;
    int cyc;
    do_reset();
    tok = 8'h00;
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 20 && cyc < 600) begin
      @(negedge clk_i);
      evt_ready_i = 1'($urandom_range(0, 1));
      if (sent < 20 && (sent - recv) < 4) begin
        evt_data_i[(sent % 8)*8 +: 8] = 8'h40 + 8'(sent);
        tok = jnext(tok);
        evt_writetoken_i = tok;
        sent++;
      end
      #1;
      if (evt_valid_o && evt_ready_i) begin
        nchk++; if (evt_data_o !== 8'h40 + 8'(recv))
          $display("FAIL stream_%0d: got %h want %h", recv, evt_data_o, 8'h40 + 8'(recv));
        else npass++;
        recv++;
      end
      cyc++;
    end
    nchk++; if (recv != 20) $display("FAIL stream_count: got %0d want 20", recv); else npass++;
    @(negedge clk_i);
    evt_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    nchk++; if (evt_readpointer_o !== 8'h0F) $display("FAIL stream_rp: got %h want 0f", evt_readpointer_o); else npass++;
    nchk++; if (evt_valid_o !== 1'b0) $display("FAIL stream_valid: got %b want 0", evt_valid_o); else npass++;
    nchk++; if (evt_err_o !== 1'b0) $display("FAIL stream_err: got %b want 0", evt_err_o); else npass++;
  endtask

  // Sender jumps 9 positions ahead: sticky error.
  task automatic test_overrun();
    do_reset();
    @(posedge clk_i); #1;           // edge n
    evt_writetoken_i = 8'hFE;
    tick();
    tick();                          // n+2
    nchk++; if (evt_err_o !== 1'b0) $display("FAIL overrun_early: got %b want 0", evt_err_o); else npass++;
    tick();                          // n+3
    nchk++; if (evt_err_o !== 1'b1) $display("FAIL overrun_set: got %b want 1", evt_err_o); else npass++;
    evt_writetoken_i = 8'h01;
    for (int k = 0; k < 6; k++) tick();
    nchk++; if (evt_err_o !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", evt_err_o); else npass++;
  endtask

  // Asynchronous reset with events in flight, then a clean single event.
  task automatic test_reset_mid();
    logic [7:0] tok;
    int cyc;
    do_reset();
    for (int k = 0; k < 4; k++) evt_data_i[k*8 +: 8] = 8'h60 + 8'(k);
    tok = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tok = jnext(tok);
      evt_writetoken_i = tok;
      tick();
    end
    cyc = 0;
    while (!(evt_valid_o && evt_level_o == 4'd3) && cyc < 20) begin
      tick();
      cyc++;
    end
    nchk++; if (!(evt_valid_o === 1'b1 && evt_level_o === 4'd3 && evt_data_o === 8'h60))
      $display("FAIL midrst_setup: got valid=%b level=%0d data=%h want valid=1 level=3 data=60", evt_valid_o, evt_level_o, evt_data_o);
    else npass++;
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    nchk++; if (evt_valid_o !== 1'b0) $display("FAIL midrst_valid: got %b want 0", evt_valid_o); else npass++;
    nchk++; if (evt_data_o !== 8'h00) $display("FAIL midrst_data: got %h want 00", evt_data_o); else npass++;
    nchk++; if (evt_readpointer_o !== 8'h00) $display("FAIL midrst_rp: got %h want 00", evt_readpointer_o); else npass++;
    nchk++; if (evt_level_o !== 4'd0) $display("FAIL midrst_level: got %0d want 0", evt_level_o); else npass++;
    nchk++; if (evt_err_o !== 1'b0) $display("FAIL midrst_err: got %b want 0", evt_err_o); else npass++;
    evt_writetoken_i = 8'h00;
    evt_data_i = '0;
    tick();
    rst_i = 1'b0;
    tick();
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_ring();
    test_stream();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
